alu_issue_stage: RTL and testbench

- Operand-issue stage directly upstream of the 16-bit ALU.
- Accepts a 16-bit instruction and reads two operands from an 8-entry register file. Drives A, B and ALU_Sel to the ALU through one registered pipeline slot with valid/ready handshakes.
- The ALU result returns through a write-back port. A pending-register scoreboard stalls issue on read-after-write and write-after-write hazards.

---
 rtl/alu_issue_pkg.sv | 35 +++
 rtl/alu_issue_regfile.sv | 36 +++
 rtl/alu_issue_stage.sv | 97 +++++++++
 tb/tb_alu_issue_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU operand-issue stage: op codes, field positions, widths.
package alu_issue_pkg;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 6;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_NE   = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_LT   = 4'b1100;
  localparam logic [3:0] OP_GE   = 4'b1101;
  localparam logic [3:0] OP_LTU  = 4'b1110;
  localparam logic [3:0] OP_GEU  = 4'b1111;

  // Instruction field positions; imm overlaps rs2 (only ADDI uses it).
  localparam int OP_MSB  = 15, OP_LSB  = 12;
  localparam int RD_MSB  = 11, RD_LSB  = 9;
  localparam int RS1_MSB = 8,  RS1_LSB = 6;
  localparam int RS2_MSB = 5,  RS2_LSB = 3;
  localparam int IMM_MSB = 5,  IMM_LSB = 0;

  // Ops 0010, 0011, 0101, 1011 have no ALU encoding and are dropped.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0010, 4'b0011, 4'b0101, 4'b1011: op_legal = 1'b0;
      default:                            op_legal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8-entry register file: R0 hardwired to zero, two read ports with write-through bypass.
module issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = alu_issue_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        rs1_addr,
  input  logic [2:0]        rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [7:0][DATA_W-1:0] regs;

  // Write port; R0 writes are discarded so it stays zero.
  always_ff @(posedge clk) begin
    if (rst)                          regs <= '0;
    else if (wb_en && wb_addr != 3'd0) regs[wb_addr] <= wb_data;
  end

  // Read ports; a same-cycle write-back to a nonzero source forwards wb_data.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (rs1_addr == 3'd0)                 rs1_data = '0;
    else if (wb_en && wb_addr == rs1_addr) rs1_data = wb_data;
    if (rs2_addr == 3'd0)                 rs2_data = '0;
    else if (wb_en && wb_addr == rs2_addr) rs2_data = wb_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage: decode, regfile read, pending-register hazard check, one output slot.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = alu_issue_pkg::DATA_W,
  parameter int IMM_W  = alu_issue_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [3:0]        ALU_Sel,
  output logic [2:0]        rd_out,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              err_illegal
);

  logic [3:0]        op;
  logic [2:0]        rd, rs1, rs2;
  logic [IMM_W-1:0]  imm;
  logic              legal, rtype, hz, slot_free, issue, drop;
  logic [7:0]        pending, clr_mask, set_mask, pend_eff;
  logic [DATA_W-1:0] rs1_data, rs2_data, imm_ext;

  assign op  = in_instr[OP_MSB:OP_LSB];
  assign rd  = in_instr[RD_MSB:RD_LSB];
  assign rs1 = in_instr[RS1_MSB:RS1_LSB];
  assign rs2 = in_instr[RS2_MSB:RS2_LSB];
  assign imm = in_instr[IMM_LSB+IMM_W-1:IMM_LSB];
  assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  assign legal = op_legal(op);
  assign rtype = legal && (op != OP_ADDI);

  issue_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  // Hazard view: a register being written back this cycle is already free.
  always_comb begin
    clr_mask  = wb_en ? (8'b1 << wb_addr) : 8'b0;
    pend_eff  = pending & ~clr_mask;
    hz        = pend_eff[rs1] | (rtype & pend_eff[rs2]) | pend_eff[rd];
    slot_free = !out_valid || out_ready;
    in_ready  = legal ? (slot_free && !hz) : 1'b1;
    issue     = in_valid && in_ready && legal;
    drop      = in_valid && !legal;
    set_mask  = (issue && rd != 3'd0) ? (8'b1 << rd) : 8'b0;
  end

  // Scoreboard: set on issue beats clear on write-back; R0 never pending.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pend_eff | set_mask) & 8'hFE;
  end

  // Output slot: load on issue, hold under backpressure, empty when consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      ALU_Sel   <= OP_ADD;
      rd_out    <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      A         <= rs1_data;
      B         <= rtype ? rs2_data : imm_ext;
      ALU_Sel   <= rtype ? op : OP_ADD;
      rd_out    <= rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle pulse for each dropped illegal instruction.
  always_ff @(posedge clk) begin
    if (rst) err_illegal <= 1'b0;
    else     err_illegal <= drop;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected issues queued on accept, checked on consume.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_instr;
  logic [15:0] A, B;
  logic [3:0]  ALU_Sel;
  logic [2:0]  rd_out;
  logic        out_valid, out_ready;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        err_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sel;
    logic [2:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .A           (A),
    .B           (B),
    .ALU_Sel     (ALU_Sel),
    .rd_out      (rd_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .err_illegal (err_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] sel, input logic [2:0] rd);
    exp_t e;
    e.a = a; e.b = b; e.sel = sel; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic wb_write(input logic [2:0] addr, input logic [15:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    tick;
    wb_en = 1'b0;
  endtask

  // Consumer side: every handshake on the output slot must match the oldest expected issue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("out_A",   {16'd0, A},       {16'd0, mon_e.a});
        chk("out_B",   {16'd0, B},       {16'd0, mon_e.b});
        chk("out_sel", {28'd0, ALU_Sel}, {28'd0, mon_e.sel});
        chk("out_rd",  {29'd0, rd_out},  {29'd0, mon_e.rd});
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0000;
    tick; tick;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_A",         {16'd0, A}, 32'd0);
    chk("rst_B",         {16'd0, B}, 32'd0);
    chk("rst_sel",       {28'd0, ALU_Sel}, 32'd0);
    chk("rst_rd",        {29'd0, rd_out}, 32'd0);
    chk("rst_err",       {31'd0, err_illegal}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    wb_write(3'd1, 16'h0005);
    wb_write(3'd2, 16'h0003);

    // ADD r3,r1,r2: one-cycle issue latency
    in_valid = 1'b1; in_instr = 16'h0650;
    #1 chk("add_ready", {31'd0, in_ready}, 32'd1);
    push(16'h0005, 16'h0003, 4'h0, 3'd3);
    tick;
    in_valid = 1'b0;
    chk("add_out_valid", {31'd0, out_valid}, 32'd1);
    chk("add_A_direct",  {16'd0, A}, 32'h0005);
    wb_write(3'd3, 16'h0008);

    // ADDI r4,r1,-2
    in_valid = 1'b1; in_instr = 16'h187E;
    #1 chk("addi_ready", {31'd0, in_ready}, 32'd1);
    push(16'h0005, 16'hFFFE, 4'h0, 3'd4);
    tick;
    in_valid = 1'b0;
    wb_write(3'd4, 16'h0003);

    // RAW: SUB r5,r1,r2 then XOR r6,r5,r1 stalls until r5 is written back
    in_valid = 1'b1; in_instr = 16'hAA50;
    push(16'h0005, 16'h0003, 4'hA, 3'd5);
    tick;
    in_instr = 16'h4D48;
    #1 chk("raw_stall0", {31'd0, in_ready}, 32'd0);
    tick;
    #1 chk("raw_stall1", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h0002;
    #1 chk("raw_wb_ready", {31'd0, in_ready}, 32'd1);
    push(16'h0002, 16'h0005, 4'h4, 3'd6);
    tick;
    in_valid = 1'b0; wb_en = 1'b0;

    // WAW: r6 pending blocks a new writer of r6 until its write-back
    in_instr = 16'h0C50;
    #1 chk("waw_stall", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'h0007;
    #1 chk("waw_clear", {31'd0, in_ready}, 32'd1);
    tick;
    wb_en = 1'b0;

    // Backpressure: ADD r7 held for 3 cycles, OR r3 waits for the slot
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0E50;
    push(16'h0005, 16'h0003, 4'h0, 3'd7);
    tick;
    in_instr = 16'h6650;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready",  {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_A",         {16'd0, A}, 32'h0005);
      chk("bp_B",         {16'd0, B}, 32'h0003);
      chk("bp_rd",        {29'd0, rd_out}, 32'd7);
      tick;
    end
    out_ready = 1'b1;
    #1 chk("bp_accept", {31'd0, in_ready}, 32'd1);
    push(16'h0005, 16'h0003, 4'h6, 3'd3);
    tick;
    in_valid = 1'b0;
    tick;

    // Illegal op 0101: consumed, pulse, nothing issued, pending untouched
    in_valid = 1'b1; in_instr = 16'h5248;
    #1 chk("ill_ready", {31'd0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    chk("ill_err_hi",    {31'd0, err_illegal}, 32'd1);
    chk("ill_no_valid",  {31'd0, out_valid}, 32'd0);
    tick;
    chk("ill_err_lo",    {31'd0, err_illegal}, 32'd0);
    chk("ill_no_valid2", {31'd0, out_valid}, 32'd0);
    in_instr = 16'h0650;
    #1 chk("ill_r3_still_pending", {31'd0, in_ready}, 32'd0);
    in_instr = 16'h0250;
    #1 chk("ill_r1_not_pending", {31'd0, in_ready}, 32'd1);
    wb_write(3'd3, 16'h0009);
    wb_write(3'd7, 16'h0008);

    // Reset while an output is held and r3 is pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0650;
    tick;
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_A",     {16'd0, A}, 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 16'h0AD8;
    #1 chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    push(16'h0000, 16'h0000, 4'h0, 3'd5);
    tick;
    in_valid = 1'b0;
    tick; tick;

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
